dp_ram_stream_fifo: RTL

Streaming FIFO controller that wraps a simple dual-port RAM. It writes incoming words through the RAM's write port and reads them back through the read port, which has a fixed read latency. It then re-times the read data into a valid/ready output. It sits directly on both sides of the `Memory` instance: it drives the address, data and write-enable pins and consumes `data_out`. Credit-based prefetch into a small skid buffer keeps throughput at 1 word/cycle despite the RAM latency.

---
 rtl/dp_ram_stream_fifo.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dp_ram_stream_fifo.sv
// dp_ram_stream_fifo
//   Streaming FIFO controller in front of a simple dual-port RAM with a fixed
//   read latency (1 or 2). Words are written straight into the RAM. A small
//   credit-controlled skid buffer is prefetched from the RAM read port, so
//   the output sustains one word per cycle despite the read latency.
//
// Ports
//   clk_i, rst_i           single clock, synchronous active-high reset
//   in_data_i/in_valid_i/in_ready_o     write stream (ready = RAM not full)
//   out_data_o/out_valid_o/out_ready_i  read stream (head of skid buffer)
//   mem_wr_addr_o/mem_wr_data_o/mem_wr_en_o  RAM write port
//   mem_rd_addr_o          RAM read address (registered inside the RAM)
//   mem_rd_data_i          RAM read data, READ_LATENCY cycles after the address
//   level_o                words resident in the RAM (not in flight or buffered)
module dp_ram_stream_fifo #(
  parameter int unsigned DATA_WIDTH   = 14,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic [ADDR_WIDTH:0]   level_o
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("dp_ram_stream_fifo: READ_LATENCY must be 1 or 2");
  end

  localparam int unsigned BufDepth = READ_LATENCY + 1;
  localparam int unsigned IdxW     = $clog2(BufDepth);
  localparam int unsigned CntW     = $clog2(BufDepth + 1);
  localparam int unsigned CrW      = CntW + 1;
  localparam int unsigned PtrW     = ADDR_WIDTH + 1;

  localparam logic [PtrW-1:0] FullLevel   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [IdxW-1:0] LastIdx     = IdxW'(BufDepth - 1);
  localparam logic [CrW-1:0]  CreditLimit = CrW'(BufDepth);

  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q, level;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic [CntW-1:0]         buf_cnt_q, buf_cnt_d, inflight;
  logic [IdxW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [DATA_WIDTH-1:0]   buf_q [BufDepth];
  logic [DATA_WIDTH-1:0]   buf_d [BufDepth];
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CrW-1:0]          credit;
  logic                    push, pop, issue, capture;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + IdxW'(1);
  endfunction

  always_comb begin
    level       = wr_ptr_q - rd_ptr_q;
    in_ready_o  = !rst_i && (level != FullLevel);
    push        = in_valid_i && in_ready_o;
    out_valid_o = (buf_cnt_q != '0);
    pop         = out_valid_o && out_ready_i;

    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CntW'(tag_q[i]);
    end

    // Words already owed to the buffer after this edge must leave room for one more.
    credit  = CrW'(buf_cnt_q) + CrW'(inflight) - CrW'(pop);
    issue   = (level != '0) && (credit < CreditLimit);
    capture = tag_q[READ_LATENCY-1];

    tag_d    = tag_q << 1;
    tag_d[0] = issue;

    buf_d = buf_q;
    if (capture) begin
      buf_d[tail_q] = mem_rd_data_i;
    end
    tail_d    = capture ? next_idx(tail_q) : tail_q;
    head_d    = pop ? next_idx(head_q) : head_q;
    buf_cnt_d = buf_cnt_q + CntW'(capture) - CntW'(pop);
    // Register the next head so out_data_o comes straight from a flop.
    out_data_d = buf_d[head_d];

    mem_wr_en_o   = push;
    mem_wr_addr_o = wr_ptr_q[ADDR_WIDTH-1:0];
    mem_wr_data_o = in_data_i;
    mem_rd_addr_o = rd_ptr_q[ADDR_WIDTH-1:0];
    out_data_o    = out_data_q;
    level_o       = level;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_q      <= '0;
      buf_cnt_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      out_data_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      tag_q      <= tag_d;
      buf_cnt_q  <= buf_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by buf_cnt_q.
  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(capture && buf_cnt_q == CntW'(BufDepth)))
        else $error("dp_ram_stream_fifo: capture into a full skid buffer");
    end
  end
`endif

endmodule
